rdy_ack_word_packer: RTL



---
 rtl/rdy_ack_word_packer_pkg.sv | 9 +
 rtl/rdy_ack_word_packer_if.sv | 39 +++
 rtl/rdy_ack_word_packer.sv | 109 ++++++++++
 3 files changed

// File: rtl/rdy_ack_word_packer_pkg.sv
// Shared defaults for the narrow-to-wide rdy/ack word packer.
// Widths are derived from these in the interface and the packer itself.
package rdy_ack_word_packer_pkg;

  localparam int DEF_DW_M1 = 7;
  localparam int DEF_RATIO = 4;
  localparam int DEF_CW_M1 = 1;

endpackage

// File: rtl/rdy_ack_word_packer_if.sv
// Handshake bundle around the packer: narrow beat input side, wide word output side,
// plus the lane counter brought out so checkers can observe word-fill progress.
interface rdy_ack_word_packer_if
  import rdy_ack_word_packer_pkg::*;
#(
  parameter int DW_M1 = DEF_DW_M1,
  parameter int RATIO = DEF_RATIO,
  parameter int CW_M1 = DEF_CW_M1
);

  localparam int LW = DW_M1 + 1;
  localparam int WW = RATIO * LW;
  localparam int CW = CW_M1 + 1;

  // Both sides: a transfer happens on the rising edge where rdy & ack are high.
  // The producer holds data/last/keep stable while rdy is high and ack is low,
  // and never withdraws rdy before the transfer.
  logic          i_rdy;
  logic          i_ack;
  logic [LW-1:0] i_data;
  logic          i_last;
  logic          o_rdy;
  logic          o_ack;
  logic [WW-1:0] o_data;
  logic [RATIO-1:0] o_keep;
  logic          o_last;
  logic [CW-1:0] lane_cnt;

  modport master (
    output i_rdy, i_data, i_last, o_ack,
    input  i_ack, o_rdy, o_data, o_keep, o_last, lane_cnt
  );

  modport slave (
    input  i_rdy, i_data, i_last, o_ack,
    output i_ack, o_rdy, o_data, o_keep, o_last, lane_cnt
  );

endinterface

// File: rtl/rdy_ack_word_packer.sv
// Packs RATIO narrow beats (lane 0 at LSBs) into one registered wide word;
// i_last closes a partial word early with a contiguous lane mask.
module rdy_ack_word_packer
  import rdy_ack_word_packer_pkg::*;
#(
  parameter int DW_M1 = DEF_DW_M1,
  parameter int RATIO = DEF_RATIO,
  parameter int CW_M1 = DEF_CW_M1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rdy_ack_word_packer_if.slave  bus
);

  localparam int LW = DW_M1 + 1;
  localparam int WW = RATIO * LW;
  localparam int CW = CW_M1 + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WW-1:0]    acc_q,    acc_d;
  logic [RATIO-1:0] mask_q,   mask_d;
  logic             o_rdy_q,  o_rdy_d;
  logic [WW-1:0]    o_data_q, o_data_d;
  logic [RATIO-1:0] o_keep_q, o_keep_d;
  logic             o_last_q, o_last_d;

  logic             i_ack_c;
  logic             i_deal;
  logic             o_deal;
  logic             word_done;
  logic [WW-1:0]    merged_data;
  logic [RATIO-1:0] merged_keep;

  // Input side may accept whenever the output register is empty or draining this cycle.
  always_comb begin
    i_ack_c   = !o_rdy_q | bus.o_ack;
    i_deal    = bus.i_rdy & i_ack_c;
    o_deal    = o_rdy_q & bus.o_ack;
    word_done = i_deal & ((cnt_q == LAST_LANE) | bus.i_last);
  end

  // Accumulator with the current beat dropped into its lane.
  always_comb begin
    merged_data = acc_q;
    merged_keep = mask_q;
    for (int l = 0; l < RATIO; l++) begin
      if (cnt_q == CW'(l)) begin
        merged_data[l*LW +: LW] = bus.i_data;
        merged_keep[l]          = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    o_rdy_d  = o_rdy_q;
    o_data_d = o_data_q;
    o_keep_d = o_keep_q;
    o_last_d = o_last_q;
    if (o_deal) begin
      o_rdy_d = 1'b0;
    end
    // Completion wins over a same-cycle drain, giving back-to-back words.
    if (word_done) begin
      o_rdy_d  = 1'b1;
      o_data_d = merged_data;
      o_keep_d = merged_keep;
      o_last_d = bus.i_last;
      cnt_d    = '0;
      acc_d    = '0;
      mask_d   = '0;
    end else if (i_deal) begin
      cnt_d  = cnt_q + CW'(1);
      acc_d  = merged_data;
      mask_d = merged_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mask_q   <= '0;
      o_rdy_q  <= 1'b0;
      o_data_q <= '0;
      o_keep_q <= '0;
      o_last_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      o_rdy_q  <= o_rdy_d;
      o_data_q <= o_data_d;
      o_keep_q <= o_keep_d;
      o_last_q <= o_last_d;
    end
  end

  assign bus.i_ack    = i_ack_c;
  assign bus.o_rdy    = o_rdy_q;
  assign bus.o_data   = o_data_q;
  assign bus.o_keep   = o_keep_q;
  assign bus.o_last   = o_last_q;
  assign bus.lane_cnt = cnt_q;

endmodule
